bmd_axist_pm_ctrl: RTL

Multi-function power-management turn-off controller for the BMD AXI-ST endpoint, replacing the single-function turn-off controller. It tracks outstanding completions per PCIe function and blocks new requests on the function whose power state is changing. It acknowledges `cfg_power_state_change_interrupt` only after that function's completions have drained, with an optional drain timeout. It sits beside the BMD EP engine, between the completer request/completion paths and the core's power-management handshake.

---
 rtl/bmd_axist_pm_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/bmd_axist_pm_ctrl.sv
// bmd_axist_pm_ctrl
// Multi-function power-management turn-off controller for the BMD AXI-ST
// endpoint. Counts outstanding completions per PCIe function, blocks new
// requests on the function whose power state is changing, and acknowledges
// cfg_power_state_change_interrupt once that function has drained.
// Optional feature macro: BMD_PM_TIMEOUT_EN (bounded drain with a sticky
// pm_timeout_err); when undefined, DRAIN waits indefinitely.
module bmd_axist_pm_ctrl #(
    parameter int NUM_FUNC    = 4,
    parameter int FUNC_W      = (NUM_FUNC > 1) ? $clog2(NUM_FUNC) : 1,
    parameter int CNT_W       = 6,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                user_clk,
    input  logic                user_reset,
    input  logic                req_compl_vld,
    input  logic [FUNC_W-1:0]   req_compl_func,
    input  logic                compl_done_vld,
    input  logic [FUNC_W-1:0]   compl_done_func,
    input  logic                cfg_power_state_change_interrupt,
    input  logic [FUNC_W-1:0]   cfg_power_state_change_func,
    output logic                cfg_power_state_change_ack,
    output logic [NUM_FUNC-1:0] req_blocked,
    output logic                pm_busy,
    output logic                cnt_err,
    output logic                pm_timeout_err
);

    typedef enum logic [1:0] {
        IDLE          = 2'd0,
        DRAIN         = 2'd1,
        ACK           = 2'd2,
        WAIT_DEASSERT = 2'd3
    } state_t;

    state_t              state;
    logic [FUNC_W-1:0]   pm_func;
    logic                intr_q;
    logic [CNT_W-1:0]    cnt [NUM_FUNC];
    logic [CNT_W-1:0]    cnt_sel;
    logic [NUM_FUNC-1:0] inc_vec;
    logic [NUM_FUNC-1:0] dec_vec;

`ifdef BMD_PM_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC);
    logic [TMO_W-1:0] tmo_cnt;
`endif

    // One-hot mask for a function index; out-of-range indices give an empty mask.
    function automatic logic [NUM_FUNC-1:0] func_mask(input logic [FUNC_W-1:0] f);
        logic [NUM_FUNC-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_FUNC; i++) begin
            if (f == FUNC_W'(i)) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Decode the request/completion pulses into per-function increment/decrement strobes.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (req_compl_vld)  inc_vec = func_mask(req_compl_func);
        if (compl_done_vld) dec_vec = func_mask(compl_done_func);
    end

    // Select the registered count of the function currently being drained.
    always_comb begin
        cnt_sel = '0;
        for (int i = 0; i < NUM_FUNC; i++) begin
            if (pm_func == FUNC_W'(i)) cnt_sel = cnt[i];
        end
    end

    // Per-function outstanding-completion counters; saturate at both ends and flag it.
    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            for (int i = 0; i < NUM_FUNC; i++) cnt[i] <= '0;
            cnt_err <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_FUNC; i++) begin
                if (inc_vec[i] && !dec_vec[i]) begin
                    if (&cnt[i]) cnt_err <= 1'b1;
                    else         cnt[i]  <= cnt[i] + CNT_W'(1);
                end else if (dec_vec[i] && !inc_vec[i]) begin
                    if (cnt[i] == '0) cnt_err <= 1'b1;
                    else              cnt[i]  <= cnt[i] - CNT_W'(1);
                end
            end
        end
    end

    // Power-state handshake FSM: latch function on interrupt edge, drain, ack, wait for release.
    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            state                      <= IDLE;
            pm_func                    <= '0;
            intr_q                     <= 1'b0;
            req_blocked                <= '0;
            pm_busy                    <= 1'b0;
            cfg_power_state_change_ack <= 1'b0;
`ifdef BMD_PM_TIMEOUT_EN
            tmo_cnt                    <= '0;
            pm_timeout_err             <= 1'b0;
`endif
        end else begin
            intr_q                     <= cfg_power_state_change_interrupt;
            cfg_power_state_change_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_power_state_change_interrupt && !intr_q) begin
                        state       <= DRAIN;
                        pm_func     <= cfg_power_state_change_func;
                        req_blocked <= func_mask(cfg_power_state_change_func);
                        pm_busy     <= 1'b1;
`ifdef BMD_PM_TIMEOUT_EN
                        tmo_cnt     <= '0;
`endif
                    end
                end
                DRAIN: begin
                    if (cnt_sel == '0) begin
                        state                      <= ACK;
                        cfg_power_state_change_ack <= 1'b1;
                    end
`ifdef BMD_PM_TIMEOUT_EN
                    else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                        // Give up waiting: ack exactly as if drained, counters untouched.
                        state                      <= ACK;
                        cfg_power_state_change_ack <= 1'b1;
                        pm_timeout_err             <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
`endif
                end
                ACK: begin
                    state <= WAIT_DEASSERT;
                end
                WAIT_DEASSERT: begin
                    if (!cfg_power_state_change_interrupt) begin
                        state       <= IDLE;
                        req_blocked <= '0;
                        pm_busy     <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef BMD_PM_TIMEOUT_EN
    assign pm_timeout_err = 1'b0;
`endif

endmodule
